dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the single-port data memory (byte-addressed, big-endian word, combinational read, clocked write).
- Master 0 is the pipeline MEM stage; master 1 is the debug/DMA loader.
- Registers each granted request and drives exactly one memory access cycle (ce/wrn/addr/data).
- Returns registered read data with a one-cycle ack; rejects misaligned word addresses.

Parameters:
- ADDR_W, 32, byte address width to memory
- DATA_W, 32, data word width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_wrn  in  1  master 0 write enable (1 = write, 0 = read)
- m0_addr  in  ADDR_W  master 0 byte address
- m0_wdata  in  DATA_W  master 0 store data
- m0_ack  out  1  master 0 transaction done, one-cycle pulse
- m0_err  out  1  qualifies m0_ack: misaligned, no access made
- m1_req/m1_wrn/m1_addr/m1_wdata/m1_ack/m1_err  same as m0, for master 1
- rdata  out  DATA_W  read data, valid with the ack of a read
- busy  out  1  high in GRANT/ACCESS/RESP
- mem_ce  out  1  memory enable
- mem_wrn  out  1  memory write enable
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory store data
- mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Reset values (async on rst high): state=IDLE; all ack/err=0; rdata=0; busy=0; mem_ce=0; mem_wrn=0; mem_addr=0; mem_wdata=0; last_gnt=1, so master 0 wins the first tie.
- FSM states: IDLE, GRANT, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant the master that is not last_gnt (round-robin).
  - On grant: latch wrn/addr/wdata and gnt into registers; set last_gnt=gnt; go to GRANT.
- GRANT:
  - If latched addr[1:0]!=0: set err; go to RESP without any memory access.
  - Otherwise: go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_ce=1, mem_wrn=latched wrn, mem_addr/mem_wdata=latched values.
  - Read: rdata<=mem_rdata at the end of this cycle.
  - Write: rdata unchanged.
  - Go to RESP.
- RESP:
  - Granted master's ack=1 (and err if set) for exactly one cycle; the other master's ack stays 0.
  - Clear err; go to IDLE.
- Outside ACCESS: mem_ce=0 and mem_wrn=0. The memory address/data outputs hold their last value.
- Latency: request sampled in IDLE at edge N; ack high during cycle N+3; back-to-back throughput is one transaction per 4 cycles.
- Requesters deassert req in the cycle after ack. A req still high in the following IDLE counts as a new transaction.
- A req dropped before ack is a protocol violation. The latched transaction completes regardless.
- Reset mid-transaction aborts immediately: no ack is issued, and mem_ce drops asynchronously.
- rdata holds between reads and is valid only with the ack of a read.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN
- Defined:
  - Adds input m1_lock (1 bit).
  - If m1_lock is high in the RESP of a master-1 transaction, the next IDLE grants master 1 if m1_req is high, ignoring round-robin and m0_req.
  - The lock holds for as long as m1_lock stays high at each master-1 RESP.
  - If m1_req is low in that IDLE, the lock is released and normal arbitration applies.
- Undefined: no m1_lock port; pure round-robin.

Test Plan:
- Reset then m0 write addr=0x10 wdata=0xDEADBEEF -> mem_ce=1, mem_wrn=1 in exactly one cycle; m0_ack pulses 3 cycles after sample; m0_err=0.
- m0 read addr=0x10 after that write -> m0_ack with rdata=0xDEADBEEF; m1_ack stays 0.
- m0 and m1 both request reads continuously -> grants alternate m0, m1, m0, m1; each ack is 4 cycles apart.
- m1 write addr=0x13 -> m1_ack=1 with m1_err=1; mem_ce never asserted; memory contents unchanged.
- rst asserted during ACCESS of an m0 write -> mem_ce=0 immediately, no ack; after release, state=IDLE and the next tie grants m0.
- With DMEM_ARB_LOCK_EN: m1_lock=1, both masters requesting -> three consecutive m1 grants; drop m1_lock -> next grant goes to m0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter/sequencer for the single-port data memory.
// Optional macro DMEM_ARB_LOCK_EN adds m1_lock so master 1 can keep the memory across transactions.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wrn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_wrn,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_ce,
  output logic              mem_wrn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  logic                r_gnt;
  logic                r_last_gnt;
  logic                r_lock;
  logic                r_wrn;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_busy, r_mem_ce, r_mem_wrn;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                w_req_any;
  logic                w_gnt;
  logic                w_take;

  always_comb begin
    w_req_any = m0_req | m1_req;
    if (m0_req && m1_req) w_gnt = ~r_last_gnt;
    else                  w_gnt = m1_req;
    if (r_lock && m1_req) w_gnt = 1'b1;
  end

  assign w_take = (r_state == S_IDLE) && w_req_any;

  // Transaction payload needs no reset: it is only consumed after a grant latches it.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_wrn   <= w_gnt ? m1_wrn   : m0_wrn;
      r_addr  <= w_gnt ? m1_addr  : m0_addr;
      r_wdata <= w_gnt ? m1_wdata : m0_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= 1'b0;
      r_last_gnt  <= 1'b1;
      r_lock      <= 1'b0;
      r_m0_ack    <= 1'b0;
      r_m0_err    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_m1_err    <= 1'b0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_mem_ce    <= 1'b0;
      r_mem_wrn   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_lock && !m1_req) r_lock <= 1'b0;
          if (w_req_any) begin
            r_gnt      <= w_gnt;
            r_last_gnt <= w_gnt;
            r_busy     <= 1'b1;
            r_state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (r_addr[1:0] != 2'b00) begin
            // Misaligned: answer with an error ack and never touch the memory.
            r_m0_ack <= ~r_gnt;
            r_m0_err <= ~r_gnt;
            r_m1_ack <= r_gnt;
            r_m1_err <= r_gnt;
            r_state  <= S_RESP;
          end else begin
            r_mem_ce    <= 1'b1;
            r_mem_wrn   <= r_wrn;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_ce  <= 1'b0;
          r_mem_wrn <= 1'b0;
          if (!r_wrn) r_rdata <= mem_rdata;
          r_m0_ack  <= ~r_gnt;
          r_m1_ack  <= r_gnt;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          r_m0_ack <= 1'b0;
          r_m0_err <= 1'b0;
          r_m1_ack <= 1'b0;
          r_m1_err <= 1'b0;
          r_busy   <= 1'b0;
`ifdef DMEM_ARB_LOCK_EN
          if (r_gnt) r_lock <= m1_lock;
`endif
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_ack    = r_m0_ack;
  assign m0_err    = r_m0_err;
  assign m1_ack    = r_m1_ack;
  assign m1_err    = r_m1_err;
  assign rdata     = r_rdata;
  assign busy      = r_busy;
  assign mem_ce    = r_mem_ce;
  assign mem_wrn   = r_mem_wrn;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word memory model.
// Build with +define+DMEM_ARB_LOCK_EN to also exercise the master-1 lock.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wrn, m1_req, m1_wrn;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] rdata;
  logic        busy, mem_ce, mem_wrn;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic        m1_lock;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:15] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003,
                              32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007,
                              32'h1000_0008, 32'h1000_0009, 32'h1000_000A, 32'h1000_000B,
                              32'h1000_000C, 32'h1000_000D, 32'h1000_000E, 32'h1000_000F};

  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_ce && mem_wrn) mem[mem_addr[5:2]] <= mem_wdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wrn(m0_wrn), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_wrn(m1_wrn), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m1_ack(m1_ack), .m1_err(m1_err),
    .rdata(rdata), .busy(busy),
    .mem_ce(mem_ce), .mem_wrn(mem_wrn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one single-master transaction and reports what was observed on the buses.
  task automatic run_txn(input int m, input logic wrn, input logic [31:0] addr, input logic [31:0] wd,
                         output int ack_k, output int ce_cnt, output int ce_k, output logic ce_wrn,
                         output logic [31:0] ce_addr, output logic [31:0] ce_wd,
                         output logic err, output logic [31:0] rd, output logic other_ack);
    ack_k = 0; ce_cnt = 0; ce_k = 0; ce_wrn = 1'b0; ce_addr = '0; ce_wd = '0;
    err = 1'b0; rd = '0; other_ack = 1'b0;
    if (m == 0) begin m0_req = 1'b1; m0_wrn = wrn; m0_addr = addr; m0_wdata = wd; end
    else        begin m1_req = 1'b1; m1_wrn = wrn; m1_addr = addr; m1_wdata = wd; end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (mem_ce) begin ce_cnt++; ce_k = k; ce_wrn = mem_wrn; ce_addr = mem_addr; ce_wd = mem_wdata; end
      if ((m == 0) ? m1_ack : m0_ack) other_ack = 1'b1;
      if ((m == 0) ? m0_ack : m1_ack) begin
        ack_k = k; err = (m == 0) ? m0_err : m1_err; rd = rdata;
        break;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    tests++;
    if ({m0_ack, m0_err, m1_ack, m1_err, busy, mem_ce, mem_wrn} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000000", {m0_ack, m0_err, m1_ack, m1_err, busy, mem_ce, mem_wrn});
    end
    tests++;
    if ({rdata, mem_addr, mem_wdata} !== 96'b0) begin
      fails++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h expected all 0", rdata, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    cyc();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_write();
    int ack_k, ce_cnt, ce_k; logic ce_wrn, err, oth; logic [31:0] ce_addr, ce_wd, rd;
    run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, ack_k, ce_cnt, ce_k, ce_wrn, ce_addr, ce_wd, err, rd, oth);
    tests++; if (ack_k !== 3) begin fails++; $display("FAIL wr_ack_cycle: got %0d expected 3", ack_k); end
    tests++; if (ce_cnt !== 1) begin fails++; $display("FAIL wr_ce_count: got %0d expected 1", ce_cnt); end
    tests++; if (ce_k !== 2) begin fails++; $display("FAIL wr_ce_cycle: got %0d expected 2", ce_k); end
    tests++; if (ce_wrn !== 1'b1) begin fails++; $display("FAIL wr_mem_wrn: got %b expected 1", ce_wrn); end
    tests++; if (ce_addr !== 32'h10) begin fails++; $display("FAIL wr_mem_addr: got %h expected 00000010", ce_addr); end
    tests++; if (ce_wd !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_mem_wdata: got %h expected deadbeef", ce_wd); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL wr_err: got %b expected 0", err); end
    tests++; if (oth !== 1'b0) begin fails++; $display("FAIL wr_m1_ack: got %b expected 0", oth); end
    tests++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_mem_content: got %h expected deadbeef", mem[4]); end
  endtask

  task automatic test_read();
    int ack_k, ce_cnt, ce_k; logic ce_wrn, err, oth; logic [31:0] ce_addr, ce_wd, rd;
    run_txn(0, 1'b0, 32'h10, 32'h0, ack_k, ce_cnt, ce_k, ce_wrn, ce_addr, ce_wd, err, rd, oth);
    tests++; if (ack_k !== 3) begin fails++; $display("FAIL rd_ack_cycle: got %0d expected 3", ack_k); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    tests++; if (ce_cnt !== 1 || ce_wrn !== 1'b0) begin fails++; $display("FAIL rd_mem_cycle: ce_cnt=%0d wrn=%b expected 1/0", ce_cnt, ce_wrn); end
    tests++; if (oth !== 1'b0) begin fails++; $display("FAIL rd_m1_ack: got %b expected 0", oth); end
  endtask

  task automatic test_misaligned();
    int ack_k, ce_cnt, ce_k; logic ce_wrn, err, oth; logic [31:0] ce_addr, ce_wd, rd;
    run_txn(1, 1'b1, 32'h13, 32'h12345678, ack_k, ce_cnt, ce_k, ce_wrn, ce_addr, ce_wd, err, rd, oth);
    tests++; if (ack_k !== 2) begin fails++; $display("FAIL mis_ack_cycle: got %0d expected 2", ack_k); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL mis_err: got %b expected 1", err); end
    tests++; if (ce_cnt !== 0) begin fails++; $display("FAIL mis_no_access: ce_cnt=%0d expected 0", ce_cnt); end
    tests++; if (oth !== 1'b0) begin fails++; $display("FAIL mis_m0_ack: got %b expected 0", oth); end
    tests++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL mis_mem_unchanged: got %h expected deadbeef", mem[4]); end
  endtask

  task automatic test_round_robin();
    int who[4]; int kk[4]; logic [31:0] rd[4]; int n = 0; int both = 0;
    int exp_who[4] = '{0, 1, 0, 1};
    logic [31:0] exp_rd[4] = '{32'hDEADBEEF, 32'h1000_0000, 32'hDEADBEEF, 32'h1000_0000};
    m0_req = 1'b1; m0_wrn = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_wrn = 1'b0; m1_addr = 32'h00;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (m0_ack && m1_ack) both++;
      if ((m0_ack || m1_ack) && n < 4) begin who[n] = m1_ack ? 1 : 0; kk[n] = k; rd[n] = rdata; n++; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    cyc(); cyc();
    tests++; if (n !== 4) begin fails++; $display("FAIL rr_ack_count: got %0d expected 4", n); end
    tests++; if (both !== 0) begin fails++; $display("FAIL rr_dual_ack: got %0d expected 0", both); end
    for (int i = 0; i < n; i++) begin
      tests++;
      if (who[i] !== exp_who[i] || kk[i] !== 3 + 4*i || rd[i] !== exp_rd[i]) begin
        fails++;
        $display("FAIL rr_grant%0d: master=%0d cycle=%0d rdata=%h expected master=%0d cycle=%0d rdata=%h",
                 i, who[i], kk[i], rd[i], exp_who[i], 3 + 4*i, exp_rd[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ack_k = 0; logic sawack = 1'b0; logic oth = 1'b0; logic [31:0] rd = '0;
    m0_req = 1'b1; m0_wrn = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hCAFEF00D;
    cyc(); cyc();
    tests++; if (mem_ce !== 1'b1) begin fails++; $display("FAIL mid_in_access: mem_ce=%b expected 1", mem_ce); end
    rst = 1'b1;
    #1;
    tests++; if (mem_ce !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL mid_async_drop: mem_ce=%b busy=%b expected 0/0", mem_ce, busy); end
    m0_req = 1'b0;
    for (int k = 0; k < 3; k++) begin cyc(); if (m0_ack) sawack = 1'b1; end
    rst = 1'b0;
    cyc();
    if (m0_ack) sawack = 1'b1;
    tests++; if (sawack !== 1'b0) begin fails++; $display("FAIL mid_no_ack: got %b expected 0", sawack); end
    tests++; if (mem[8] !== 32'h1000_0008) begin fails++; $display("FAIL mid_mem_unchanged: got %h expected 10000008", mem[8]); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_idle: busy=%b expected 0", busy); end
    m0_req = 1'b1; m0_wrn = 1'b0; m0_addr = 32'h20;
    m1_req = 1'b1; m1_wrn = 1'b0; m1_addr = 32'h04;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (m1_ack) oth = 1'b1;
      if (m0_ack) begin ack_k = k; rd = rdata; break; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    cyc(); cyc();
    tests++; if (ack_k !== 3 || oth !== 1'b0) begin fails++; $display("FAIL mid_tie_m0: m0 ack cycle=%0d m1_ack=%b expected 3/0", ack_k, oth); end
    tests++; if (rd !== 32'h1000_0008) begin fails++; $display("FAIL mid_tie_rdata: got %h expected 10000008", rd); end
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    int who[4]; int kk[4]; int n = 0; int m1_cnt = 0;
    int exp_who[4] = '{1, 1, 1, 0};
    m1_lock = 1'b1;
    m0_req = 1'b1; m0_wrn = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_wrn = 1'b0; m1_addr = 32'h04;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if ((m0_ack || m1_ack) && n < 4) begin who[n] = m1_ack ? 1 : 0; kk[n] = k; n++; end
      if (m1_ack) begin m1_cnt++; if (m1_cnt == 3) m1_lock = 1'b0; end
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    cyc(); cyc();
    tests++; if (n !== 4) begin fails++; $display("FAIL lock_ack_count: got %0d expected 4", n); end
    for (int i = 0; i < n; i++) begin
      tests++;
      if (who[i] !== exp_who[i] || kk[i] !== 3 + 4*i) begin
        fails++;
        $display("FAIL lock_grant%0d: master=%0d cycle=%0d expected master=%0d cycle=%0d", i, who[i], kk[i], exp_who[i], 3 + 4*i);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_wrn = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wrn = 1'b0; m1_addr = '0; m1_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    m1_lock = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_misaligned();
    test_round_robin();
    test_reset_mid();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
